// File: rtl/fp_div_prescale.sv
// rtl/fp_div_prescale.sv - FP32 divider operand pre-scale: classify, normalise, exponent adjust
// Define FP_DIV_DENORM_EN to normalise denormals; otherwise denormals flush to zero.
module fp_div_prescale #(
  parameter int EXP_W      = 10,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [31:0]      N,
  input  logic [31:0]      D,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      n_scaled,
  output logic [31:0]      d_scaled,
  output logic [EXP_W-1:0] exp_adj,
  output logic             q_sign,
  output logic [1:0]       special
);

  localparam logic [1:0] SP_NONE = 2'd0;
  localparam logic [1:0] SP_ZERO = 2'd1;
  localparam logic [1:0] SP_INF  = 2'd2;
  localparam logic [1:0] SP_NAN  = 2'd3;

  if (SHIFT_STEP != 1 && SHIFT_STEP != 2 && SHIFT_STEP != 4) begin : g_bad_step
    $error("fp_div_prescale: SHIFT_STEP must be 1, 2 or 4");
  end
  if (EXP_W < 10) begin : g_bad_exp_w
    $error("fp_div_prescale: EXP_W must be at least 10");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASS,
`ifdef FP_DIV_DENORM_EN
    S_NORM_N,
    S_NORM_D,
`endif
    S_DONE
  } state_t;

  state_t state_q, state_nx;

  logic [31:0]       n_op_q, n_op_nx, d_op_q, d_op_nx;
  logic [22:0]       n_frac_q, n_frac_nx, d_frac_q, d_frac_nx;
  logic signed [9:0] n_eeff_q, n_eeff_nx, d_eeff_q, d_eeff_nx;
  logic              sign_q, sign_nx;

  logic              out_valid_nx;
  logic [31:0]       n_scaled_nx, d_scaled_nx;
  logic [EXP_W-1:0]  exp_adj_nx;
  logic              q_sign_nx;
  logic [1:0]        special_nx;

  logic [7:0]        n_exp, d_exp;
  logic [22:0]       n_man, d_man;
  logic              n_nan, n_inf, n_zero, d_nan, d_inf, d_zero;
  logic [1:0]        cls_spec, spec_done;
  logic signed [9:0] n_eeff_cls, d_eeff_cls;
  logic              go_done;

  assign n_exp = n_op_q[30:23];
  assign d_exp = d_op_q[30:23];
  assign n_man = n_op_q[22:0];
  assign d_man = d_op_q[22:0];

  assign n_nan = (&n_exp) && (|n_man);
  assign n_inf = (&n_exp) && !(|n_man);
  assign d_nan = (&d_exp) && (|d_man);
  assign d_inf = (&d_exp) && !(|d_man);

`ifdef FP_DIV_DENORM_EN
  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  logic       n_den, d_den;
  logic [4:0] n_lz, d_lz;
  logic [4:0] n_cnt_q, n_cnt_nx, d_cnt_q, d_cnt_nx;
  logic [4:0] n_step, d_step;

  // Left shifts needed to bring the leading 1 of a denormal fraction to bit 23.
  function automatic logic [4:0] lead_shift(input logic [22:0] f);
    logic [4:0] s;
    s = 5'd0;
    for (int i = 0; i < 23; i++) begin
      if (f[i]) s = 5'(23 - i);
    end
    return s;
  endfunction

  assign n_den  = !(|n_exp) && (|n_man);
  assign d_den  = !(|d_exp) && (|d_man);
  assign n_zero = !(|n_exp) && !(|n_man);
  assign d_zero = !(|d_exp) && !(|d_man);
  assign n_lz   = lead_shift(n_man);
  assign d_lz   = lead_shift(d_man);

  assign n_eeff_cls = n_den ? (10'sd1 - $signed({5'd0, n_lz})) : $signed({2'b00, n_exp});
  assign d_eeff_cls = d_den ? (10'sd1 - $signed({5'd0, d_lz})) : $signed({2'b00, d_exp});
`else
  assign n_zero = !(|n_exp);
  assign d_zero = !(|d_exp);

  assign n_eeff_cls = $signed({2'b00, n_exp});
  assign d_eeff_cls = $signed({2'b00, d_exp});
`endif

  always_comb begin
    cls_spec = SP_NONE;
    if (n_nan || d_nan || (n_zero && d_zero) || (n_inf && d_inf)) cls_spec = SP_NAN;
    else if (n_inf || d_zero)                                     cls_spec = SP_INF;
    else if (n_zero || d_inf)                                     cls_spec = SP_ZERO;
  end

  always_comb begin
    state_nx     = state_q;
    n_op_nx      = n_op_q;
    d_op_nx      = d_op_q;
    n_frac_nx    = n_frac_q;
    d_frac_nx    = d_frac_q;
    n_eeff_nx    = n_eeff_q;
    d_eeff_nx    = d_eeff_q;
    sign_nx      = sign_q;
    out_valid_nx = out_valid;
    n_scaled_nx  = n_scaled;
    d_scaled_nx  = d_scaled;
    exp_adj_nx   = exp_adj;
    q_sign_nx    = q_sign;
    special_nx   = special;
    spec_done    = SP_NONE;
    go_done      = 1'b0;
`ifdef FP_DIV_DENORM_EN
    n_cnt_nx     = n_cnt_q;
    d_cnt_nx     = d_cnt_q;
    n_step       = 5'd0;
    d_step       = 5'd0;
`endif

    case (state_q)
      S_IDLE: begin
        if (load) begin
          n_op_nx  = N;
          d_op_nx  = D;
          state_nx = S_CLASS;
        end
      end

      S_CLASS: begin
        n_frac_nx = n_man;
        d_frac_nx = d_man;
        n_eeff_nx = n_eeff_cls;
        d_eeff_nx = d_eeff_cls;
        sign_nx   = (cls_spec == SP_NAN) ? 1'b0 : (n_op_q[31] ^ d_op_q[31]);
`ifdef FP_DIV_DENORM_EN
        n_cnt_nx  = n_den ? n_lz : 5'd0;
        d_cnt_nx  = d_den ? d_lz : 5'd0;
`endif
        if (cls_spec != SP_NONE) begin
          spec_done = cls_spec;
          go_done   = 1'b1;
        end
`ifdef FP_DIV_DENORM_EN
        else if (n_den) state_nx = S_NORM_N;
        else if (d_den) state_nx = S_NORM_D;
`endif
        else go_done = 1'b1;
      end

`ifdef FP_DIV_DENORM_EN
      // The final step is clipped to the remaining distance so bit 23 is never overshot.
      S_NORM_N: begin
        n_step    = (n_cnt_q < STEP) ? n_cnt_q : STEP;
        n_frac_nx = n_frac_q << n_step;
        n_cnt_nx  = n_cnt_q - n_step;
        if (n_cnt_q == n_step) begin
          if (d_cnt_q != 5'd0) state_nx = S_NORM_D;
          else                 go_done  = 1'b1;
        end
      end

      S_NORM_D: begin
        d_step    = (d_cnt_q < STEP) ? d_cnt_q : STEP;
        d_frac_nx = d_frac_q << d_step;
        d_cnt_nx  = d_cnt_q - d_step;
        if (d_cnt_q == d_step) go_done = 1'b1;
      end
`endif

      S_DONE: begin
        if (out_ready) begin
          state_nx     = S_IDLE;
          out_valid_nx = 1'b0;
        end
      end

      default: state_nx = S_IDLE;
    endcase

    if (go_done) begin
      state_nx     = S_DONE;
      out_valid_nx = 1'b1;
      special_nx   = spec_done;
      q_sign_nx    = sign_nx;
      if (spec_done != SP_NONE) begin
        n_scaled_nx = 32'd0;
        d_scaled_nx = 32'd0;
        exp_adj_nx  = '0;
      end else begin
        n_scaled_nx = {1'b0, 8'd126, n_frac_nx};
        d_scaled_nx = {1'b0, 8'd126, d_frac_nx};
        exp_adj_nx  = EXP_W'(n_eeff_nx) - EXP_W'(d_eeff_nx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      n_op_q    <= '0;
      d_op_q    <= '0;
      n_frac_q  <= '0;
      d_frac_q  <= '0;
      n_eeff_q  <= '0;
      d_eeff_q  <= '0;
      sign_q    <= 1'b0;
      out_valid <= 1'b0;
      n_scaled  <= '0;
      d_scaled  <= '0;
      exp_adj   <= '0;
      q_sign    <= 1'b0;
      special   <= SP_NONE;
`ifdef FP_DIV_DENORM_EN
      n_cnt_q   <= '0;
      d_cnt_q   <= '0;
`endif
    end else if (en) begin
      state_q   <= state_nx;
      n_op_q    <= n_op_nx;
      d_op_q    <= d_op_nx;
      n_frac_q  <= n_frac_nx;
      d_frac_q  <= d_frac_nx;
      n_eeff_q  <= n_eeff_nx;
      d_eeff_q  <= d_eeff_nx;
      sign_q    <= sign_nx;
      out_valid <= out_valid_nx;
      n_scaled  <= n_scaled_nx;
      d_scaled  <= d_scaled_nx;
      exp_adj   <= exp_adj_nx;
      q_sign    <= q_sign_nx;
      special   <= special_nx;
`ifdef FP_DIV_DENORM_EN
      n_cnt_q   <= n_cnt_nx;
      d_cnt_q   <= d_cnt_nx;
`endif
    end
  end

  assign in_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_fp_div_prescale.sv
// tb/tb_fp_div_prescale.sv - scoreboard bench for fp_div_prescale (default parameters)
`timescale 1ns/1ps
module tb_fp_div_prescale;

  localparam int STEP   = 1;
  localparam int K_NORM = 0;
  localparam int K_ZERO = 1;
  localparam int K_INF  = 2;
  localparam int K_NAN  = 3;

  typedef struct {
    logic [31:0] ns;
    logic [31:0] ds;
    logic [9:0]  ea;
    logic        qs;
    logic [1:0]  sp;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        load = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] n_in = '0;
  logic [31:0] d_in = '0;
  logic        in_ready, out_valid, q_sign;
  logic [31:0] n_scaled, d_scaled;
  logic [9:0]  exp_adj;
  logic [1:0]  special;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  localparam logic [31:0] B2B_N [3] = '{32'h40C00000, 32'hC1200000, 32'h7F800000};
  localparam logic [31:0] B2B_D [3] = '{32'h40400000, 32'h40E00000, 32'h3F800000};

  fp_div_prescale dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .N(n_in), .D(d_in),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .n_scaled(n_scaled), .d_scaled(d_scaled), .exp_adj(exp_adj),
    .q_sign(q_sign), .special(special)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic int kind_of(input logic [31:0] x);
    if (x[30:23] == 8'hFF) return (x[22:0] != 23'd0) ? K_NAN : K_INF;
    if (x[30:23] == 8'h00) begin
`ifdef FP_DIV_DENORM_EN
      return (x[22:0] == 23'd0) ? K_ZERO : K_NORM;
`else
      return K_ZERO;
`endif
    end
    return K_NORM;
  endfunction

  // Reference: walk the significand up to the hidden bit, decrementing the exponent.
  function automatic exp_t model(input logic [31:0] n, input logic [31:0] d, input int gap);
    exp_t r;
    int kn, kd, en_x, ed_x, lzn, lzd;
    logic [23:0] mn, md;
    kn = kind_of(n);
    kd = kind_of(d);
    r.ns = '0; r.ds = '0; r.ea = '0; r.sp = 2'd0;
    r.qs = n[31] ^ d[31];
    r.lat = 2 + gap;
    if (kn == K_NAN || kd == K_NAN || (kn == K_ZERO && kd == K_ZERO) || (kn == K_INF && kd == K_INF)) begin
      r.sp = 2'd3;
      r.qs = 1'b0;
    end else if (kn == K_INF || kd == K_ZERO) begin
      r.sp = 2'd2;
    end else if (kn == K_ZERO || kd == K_INF) begin
      r.sp = 2'd1;
    end else begin
      mn = {|n[30:23], n[22:0]};
      md = {|d[30:23], d[22:0]};
      en_x = (|n[30:23]) ? int'(n[30:23]) : 1;
      ed_x = (|d[30:23]) ? int'(d[30:23]) : 1;
      lzn = 0;
      lzd = 0;
      while (!mn[23]) begin mn = mn << 1; en_x--; lzn++; end
      while (!md[23]) begin md = md << 1; ed_x--; lzd++; end
      r.ns = {1'b0, 8'd126, mn[22:0]};
      r.ds = {1'b0, 8'd126, md[22:0]};
      r.ea = 10'(en_x - ed_x);
      r.lat = r.lat + (lzn + STEP - 1) / STEP + (lzd + STEP - 1) / STEP;
    end
    return r;
  endfunction

  function automatic exp_t mk(input logic [31:0] ns, input logic [31:0] ds, input logic [9:0] ea,
                              input logic qs, input logic [1:0] sp, input int lat);
    exp_t r;
    r.ns = ns; r.ds = ds; r.ea = ea; r.qs = qs; r.sp = sp; r.lat = lat;
    return r;
  endfunction

  // Drive one operation from a negedge in IDLE, score it, hold it, then release it.
  task automatic run_op(input int id, input logic [31:0] n, input logic [31:0] d,
                        input exp_t want, input int hold, input int gap);
    exp_t e;
    int cyc;
    sb.push_back(want);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL op%0d in_ready_before_load got %b want 1", id, in_ready);
    end
    n_in = n; d_in = d; load = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    load = 1'b0;
    if (gap > 0) begin
      en = 1'b0;
      repeat (gap) begin @(posedge clk); cyc++; end
      @(negedge clk);
      en = 1'b1;
    end
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    e = sb.pop_front();
    checks++;
    if (cyc !== e.lat) begin errors++; $display("FAIL op%0d latency got %0d want %0d", id, cyc, e.lat); end
    checks++;
    if (n_scaled !== e.ns) begin errors++; $display("FAIL op%0d n_scaled got %h want %h", id, n_scaled, e.ns); end
    checks++;
    if (d_scaled !== e.ds) begin errors++; $display("FAIL op%0d d_scaled got %h want %h", id, d_scaled, e.ds); end
    checks++;
    if (exp_adj !== e.ea) begin errors++; $display("FAIL op%0d exp_adj got %0d want %0d", id, $signed(exp_adj), $signed(e.ea)); end
    checks++;
    if (special !== e.sp) begin errors++; $display("FAIL op%0d special got %b want %b", id, special, e.sp); end
    checks++;
    if (q_sign !== e.qs) begin errors++; $display("FAIL op%0d q_sign got %b want %b", id, q_sign, e.qs); end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || n_scaled !== e.ns || d_scaled !== e.ds ||
          exp_adj !== e.ea || special !== e.sp || q_sign !== e.qs) begin
        errors++;
        $display("FAIL op%0d hold%0d got v=%b r=%b ns=%h ds=%h ea=%h sp=%b qs=%b want v=1 r=0 ns=%h ds=%h ea=%h sp=%b qs=%b",
                 id, k, out_valid, in_ready, n_scaled, d_scaled, exp_adj, special, q_sign,
                 e.ns, e.ds, e.ea, e.sp, e.qs);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL op%0d release got in_ready=%b out_valid=%b want 1 0", id, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    checks++;
    if ({n_scaled, d_scaled, exp_adj, q_sign, special} !== 77'd0) begin
      errors++;
      $display("FAIL reset_outputs got ns=%h ds=%h ea=%h qs=%b sp=%b want all 0",
               n_scaled, d_scaled, exp_adj, q_sign, special);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_normal();
    run_op(1, 32'h40C00000, 32'h40400000, mk(32'h3F400000, 32'h3F400000, 10'd1, 1'b0, 2'd0, 2), 0, 0);
    run_op(2, 32'h3F800000, 32'h3F800000, model(32'h3F800000, 32'h3F800000, 0), 0, 0);
    run_op(3, 32'hC1200000, 32'h40E00000, model(32'hC1200000, 32'h40E00000, 0), 0, 0);
    run_op(4, 32'h7F7FFFFF, 32'h00800000, model(32'h7F7FFFFF, 32'h00800000, 0), 0, 0);
    run_op(5, 32'h00800000, 32'h7F7FFFFF, model(32'h00800000, 32'h7F7FFFFF, 0), 0, 0);
  endtask

  task automatic test_denorm();
`ifdef FP_DIV_DENORM_EN
    run_op(10, 32'h3F800000, 32'h00000001, mk(32'h3F000000, 32'h3F000000, 10'd149, 1'b0, 2'd0, 25), 0, 0);
`else
    run_op(10, 32'h3F800000, 32'h00000001, mk(32'h0, 32'h0, 10'd0, 1'b0, 2'd2, 2), 0, 0);
`endif
    run_op(11, 32'h00400000, 32'h00000003, model(32'h00400000, 32'h00000003, 0), 0, 0);
    run_op(12, 32'h80000010, 32'h3F800000, model(32'h80000010, 32'h3F800000, 0), 0, 0);
    run_op(13, 32'h00000001, 32'h00000001, model(32'h00000001, 32'h00000001, 0), 0, 0);
  endtask

  task automatic test_special();
    run_op(20, 32'h80000000, 32'h00000000, mk(32'h0, 32'h0, 10'd0, 1'b0, 2'd3, 2), 0, 0);
    run_op(21, 32'hC0000000, 32'h7F800000, mk(32'h0, 32'h0, 10'd0, 1'b1, 2'd1, 2), 0, 0);
    run_op(22, 32'h7FC00000, 32'h3F800000, model(32'h7FC00000, 32'h3F800000, 0), 0, 0);
    run_op(23, 32'h7F800000, 32'hFF800000, model(32'h7F800000, 32'hFF800000, 0), 0, 0);
    run_op(24, 32'hFF800000, 32'h40000000, model(32'hFF800000, 32'h40000000, 0), 0, 0);
    run_op(25, 32'h3F800000, 32'h80000000, model(32'h3F800000, 32'h80000000, 0), 0, 0);
    run_op(26, 32'h00000000, 32'hC0000000, model(32'h00000000, 32'hC0000000, 0), 0, 0);
    run_op(27, 32'hC0000000, 32'h7FC00001, model(32'hC0000000, 32'h7FC00001, 0), 0, 0);
  endtask

  task automatic test_backpressure();
    run_op(30, 32'h40C00000, 32'h40400000, mk(32'h3F400000, 32'h3F400000, 10'd1, 1'b0, 2'd0, 2), 5, 0);
  endtask

  task automatic test_reset_mid();
    n_in = 32'h3F800000; d_in = 32'h00000001; load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        {n_scaled, d_scaled, exp_adj, q_sign, special} !== 77'd0) begin
      errors++;
      $display("FAIL reset_mid got in_ready=%b out_valid=%b ns=%h ds=%h ea=%h qs=%b sp=%b want 1 0 and zeros",
               in_ready, out_valid, n_scaled, d_scaled, exp_adj, q_sign, special);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(40, 32'h40C00000, 32'h40400000, mk(32'h3F400000, 32'h3F400000, 10'd1, 1'b0, 2'd0, 2), 0, 0);
  endtask

  task automatic test_enable();
    run_op(50, 32'h40C00000, 32'h40400000, mk(32'h3F400000, 32'h3F400000, 10'd1, 1'b0, 2'd0, 5), 0, 3);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(B2B_N[i], B2B_D[i], 0));
      n_in = B2B_N[i]; d_in = B2B_D[i]; load = 1'b1;
      @(posedge clk);
      cyc = 1;
      @(negedge clk);
      load = 1'b0;
      while (out_valid !== 1'b1 && cyc < 200) begin
        @(posedge clk);
        cyc++;
        @(negedge clk);
      end
      e = sb.pop_front();
      checks++;
      if (cyc !== e.lat || n_scaled !== e.ns || d_scaled !== e.ds || exp_adj !== e.ea ||
          special !== e.sp || q_sign !== e.qs) begin
        errors++;
        $display("FAIL b2b%0d result got lat=%0d ns=%h ds=%h ea=%h sp=%b qs=%b want lat=%0d ns=%h ds=%h ea=%h sp=%b qs=%b",
                 i, cyc, n_scaled, d_scaled, exp_adj, special, q_sign, e.lat, e.ns, e.ds, e.ea, e.sp, e.qs);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b%0d in_ready_in_done got %b want 0", i, in_ready);
      end
      n_in = 32'h7FC00000; d_in = 32'h00000000; load = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b%0d done_load_ignored got in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_denorm();
    test_special();
    test_backpressure();
    test_reset_mid();
    test_enable();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
